// File: rtl/seq_gen_param.sv
// Parameterised sequence generator: binary up, Johnson, Fibonacci LFSR and ring modes.
// Define SEQGEN_LOCKUP_RECOVER_EN to make a step from a lock-up state load a recovery value.
module seq_gen_param #(
  parameter int unsigned     W    = 8,
  parameter logic [W-1:0]    SEED = W'(1),
  parameter logic [W-1:0]    TAPS = W'(8'hB8)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic [1:0]   mode,
  output logic [W-1:0] y,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  if (W < 4 || W > 16) begin : g_bad_w
    $error("seq_gen_param: W must be in 4..16");
  end

  logic [W-1:0] y_q;
  logic [W-1:0] start_q;
  logic         wrap_q;
  logic [W-1:0] step_nxt;
  logic         recover;
  logic [W-1:0] recover_val;

  always_comb begin
    step_nxt = y_q;
    unique case (mode)
      2'b00:   step_nxt = y_q + ONE;
      2'b01:   step_nxt = {y_q[W-2:0], ~y_q[W-1]};
      2'b10:   step_nxt = {y_q[W-2:0], ^(y_q & TAPS)};
      2'b11:   step_nxt = {y_q[W-2:0], y_q[W-1]};
      default: step_nxt = y_q;
    endcase
  end

`ifdef SEQGEN_LOCKUP_RECOVER_EN
  logic [W-1:0] y_inv;
  logic         johnson_ok;
  logic         onehot;

  // Legal Johnson codes are 0*1* or 1*0*: either y or ~y is of the form 2^k-1.
  assign y_inv      = ~y_q;
  assign johnson_ok = ((y_q & (y_q + ONE)) == '0) || ((y_inv & (y_inv + ONE)) == '0);
  assign onehot     = (y_q != '0) && ((y_q & (y_q - ONE)) == '0);

  always_comb begin
    recover     = 1'b0;
    recover_val = '0;
    unique case (mode)
      2'b01: begin
        if (!johnson_ok) begin
          recover     = 1'b1;
          recover_val = '0;
        end
      end
      2'b10: begin
        if (y_q == '0) begin
          recover     = 1'b1;
          recover_val = SEED;
        end
      end
      2'b11: begin
        if (!onehot) begin
          recover     = 1'b1;
          recover_val = ONE;
        end
      end
      default: begin
        recover     = 1'b0;
        recover_val = '0;
      end
    endcase
  end
`else
  assign recover     = 1'b0;
  assign recover_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= SEED;
      start_q <= SEED;
      wrap_q  <= 1'b0;
    end else if (ld) begin
      y_q     <= ld_val;
      start_q <= ld_val;
      wrap_q  <= 1'b0;
    end else if (en) begin
      if (recover) begin
        y_q    <= recover_val;
        wrap_q <= 1'b0;
      end else begin
        y_q    <= step_nxt;
        wrap_q <= (step_nxt == start_q);
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign y    = y_q;
  assign wrap = wrap_q;

endmodule
